// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: FSM state encodings, address width and
// PC step. The debug and control units decode the same state codes, so the
// numeric values here are fixed and must not be reordered.
package cpu_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;

    // Sequential instructions are one 32-bit word apart.
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    // Raw 3-bit encodings, usable by blocks that only see the debug bus.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_WAIT   = ST_WAIT,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_HALTED = ST_HALTED,
        S_FAULT  = ST_FAULT
    } seq_state_e;

    // Instruction addresses are always word aligned; the low two bits of
    // any externally supplied address are discarded.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    // Sequential successor; wraps modulo 2^32 with no carry-out.
    function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] addr);
        return addr + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Wait-state counter for the fetch handshake. Cleared when a fetch is
// launched, counts every WAIT cycle without an acknowledge, and flags the
// cycle in which one more unanswered cycle would reach LIMIT.
module fetch_timer #(
    parameter int unsigned LIMIT = 15,
    parameter int unsigned TW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [TW-1:0] count;

    // Up-counter: clear has priority over enable.
    // NOTE: async reset sits in the sensitivity list; state uses <= so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    // The current WAIT cycle is the LIMIT-th one; no ack now means timeout.
    assign last = (count == TW'(LIMIT - 1));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/execute sequencer. Owns the program counter, issues instruction
// fetches over a req/ack handshake, loads the instruction register, hands
// the instruction to execute and applies PC+4 or a redirect afterwards.
// Runs at best one instruction every four cycles:
// FETCH -> WAIT -> DECODE -> EXEC.
module pc_fetch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        exec_done,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_tgt,
    output logic [31:0] pc,
    output logic        fault,
    output logic [2:0]  state
);

    seq_state_e cur;
    logic       timer_clear;
    logic       timer_en;
    logic       timer_last;

    // Low target bits are deliberately dropped by word_align.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^redirect_tgt[1:0];

    // Restart the wait count on every fetch launch; count unanswered WAIT cycles.
    assign timer_clear = (cur == S_FETCH);
    assign timer_en    = (cur == S_WAIT) && !mem_ack;

    fetch_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .clr    (clr),
        .clear  (timer_clear),
        .enable (timer_en),
        .last   (timer_last)
    );

    assign state = cur;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cur      <= S_IDLE;
            // A misaligned reset vector is silently aligned rather than
            // producing a fetch the memory cannot serve.
            pc       <= word_align(RESET_VEC);
            ir       <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ir_valid <= 1'b0;
            fault    <= 1'b0;
        end else begin
            // ir_valid is a single-cycle pulse covering the DECODE state.
            ir_valid <= 1'b0;

            case (cur)
                S_IDLE: begin
                    if (run) begin
                        cur <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    mem_addr <= pc;
                    mem_req  <= 1'b1;
                    cur      <= S_WAIT;
                end

                S_WAIT: begin
                    // An ack in the timeout cycle still completes the fetch.
                    if (mem_ack) begin
                        ir       <= mem_rdata;
                        pc       <= next_seq_pc(pc);
                        mem_req  <= 1'b0;
                        ir_valid <= 1'b1;
                        cur      <= S_DECODE;
                    end else if (timer_last) begin
                        mem_req <= 1'b0;
                        fault   <= 1'b1;
                        cur     <= S_FAULT;
                    end
                end

                S_DECODE: begin
                    cur <= S_EXEC;
                end

                S_EXEC: begin
                    // halt/redirect are qualified by exec_done; halt wins.
                    if (exec_done) begin
                        if (halt) begin
                            cur <= S_HALTED;
                        end else begin
                            if (redirect) begin
                                pc <= word_align(redirect_tgt);
                            end
                            cur <= run ? S_FETCH : S_IDLE;
                        end
                    end
                end

                S_HALTED, S_FAULT: begin
                    // Terminal until reset.
                end

                default: begin
                    mem_req <= 1'b0;
                    cur     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Multi-cycle fetch/execute sequencer that owns the program counter and drives instruction fetch over a req/ack memory handshake. It loads the instruction register and hands each instruction to decode/execute. It applies PC+4 or a branch/jump redirect once execute completes. It sits between the memory interface and the control unit and replaces ad-hoc incPC/enable pulsing of a bare PC register.

Parameters:
RESET_VEC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0
MEM_TIMEOUT, 15, max WAIT cycles without mem_ack before fault (1..255)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, asynchronous, active-low (clr=0 resets)
run  in  1  level; permits starting the next instruction
mem_req  out  1  fetch request, registered
mem_addr  out  32  fetch address, registered, valid while mem_req=1
mem_ack  in  1  memory data valid this cycle
mem_rdata  in  32  instruction word, sampled when mem_ack=1 in WAIT
ir  out  32  instruction register
ir_valid  out  1  one-cycle pulse: ir holds a new instruction
exec_done  in  1  execute stage finished current instruction
halt  in  1  sampled with exec_done; current instruction is HALT
redirect  in  1  sampled with exec_done; take redirect_tgt
redirect_tgt  in  32  branch/jump target
pc  out  32  address of next instruction to fetch
fault  out  1  sticky memory-timeout flag
state  out  3  current FSM state, for debug/bench

Behaviour:
- Async reset (clr=0): state=IDLE, pc=RESET_VEC, ir=0, mem_req=0, mem_addr=0, ir_valid=0, fault=0, timer=0. mem_req drops immediately, even mid-WAIT.
- Encoding: IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, HALTED=5, FAULT=6. All other codes go to IDLE.
- IDLE: run=1 -> FETCH; otherwise hold.
- FETCH (1 cycle): mem_addr<=pc, mem_req<=1, timer<=0 -> WAIT.
- WAIT:
  - mem_req stays 1 and mem_addr stays stable until ack.
  - mem_ack=1: ir<=mem_rdata, pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), mem_req<=0 -> DECODE.
  - No ack: timer++. If the timer reaches MEM_TIMEOUT (MEM_TIMEOUT WAIT cycles with no ack): mem_req<=0, fault<=1 -> FAULT.
  - Ack in the timeout cycle: ack wins, no fault.
- DECODE (1 cycle): ir_valid=1 -> EXEC. ir_valid is 0 in every other state.
- EXEC: wait for exec_done=1. halt, redirect and redirect_tgt are ignored unless exec_done=1. When exec_done=1:
  - Priority: halt > redirect.
  - halt=1 -> HALTED; pc unchanged.
  - redirect=1 -> pc<={redirect_tgt[31:2],2'b00}, low bits forced to 0.
  - If not halted: next state is FETCH if run=1, else IDLE.
- run deasserted mid-instruction: the current instruction completes, then the FSM parks in IDLE.
- HALTED and FAULT are terminal until clr. fault remains 1 in FAULT.
- Minimum cost per instruction with zero-wait memory and immediate exec_done: FETCH, WAIT, DECODE, EXEC = 4 cycles.
- Width rules: timer is clog2(MEM_TIMEOUT+1) bits. PC arithmetic is unsigned 32-bit with no carry-out.

Decomposition:
- Shared package cpu_ctrl_pkg holds the state encodings (3-bit localparams), PC_STEP=4, and ADDR_W=32. The debug and control units reuse the same encodings.
- One natural sub-module, fetch_timer: a loadable up-counter with clear/enable and a terminal-count output, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset then run=1; memory acks in the first WAIT cycle with 32'h1234_5678; exec_done one cycle after ir_valid -> mem_addr=0, ir=32'h1234_5678, pc=4, second fetch at address 4, 4 cycles per instruction.
- Memory acks in the 3rd WAIT cycle -> mem_req held for 3 cycles with mem_addr stable, then ir loaded and pc incremented by exactly 4.
- exec_done=1, redirect=1, redirect_tgt=32'h0000_0103 -> next mem_addr=32'h0000_0100. A redirect pulse without exec_done leaves pc unchanged.
- No ack for 15 WAIT cycles -> fault=1, state=FAULT, mem_req=0. The same test with ack on cycle 15 -> no fault.
- pc=32'hFFFF_FFFC fetch acked -> pc=0. exec_done with halt=1 and redirect=1 -> HALTED, pc unchanged, no further mem_req.
- clr=0 asserted mid-WAIT -> mem_req=0 in the same cycle, pc=RESET_VEC. Dropping run in EXEC -> FSM parks in IDLE after exec_done.
